pwm_rate_ctrl: RTL

Rate controller and arbiter for the PWM clock divider (`Clock`). Several requesters compete for the divider's 8-bit `Rate` input. The block grants them round-robin and applies each new rate only at a rising edge of the divider's `CLK_PWM` output, so a period is never truncated. It sits between the control logic and the divider, drives `Rate`, and observes `CLK_PWM`.

---
 rtl/pwm_rate_ctrl.sv | 194 +++++++++++++++++++
 1 files changed

// File: rtl/pwm_rate_ctrl.sv
// Round-robin rate arbiter for the PWM clock divider; a new rate is applied only on a
// rising edge of clk_pwm. Optional stall timeout: define PWM_RATE_CTRL_TIMEOUT_EN.
module pwm_rate_ctrl #(
    parameter int         NREQ      = 4,
    parameter logic [7:0] INIT_RATE = 8'd10,
    parameter logic [7:0] MIN_RATE  = 8'd2,
    parameter int         TIMEOUT   = 512
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              clk_pwm,
    input  logic [NREQ-1:0]   req,
    input  logic [8*NREQ-1:0] req_rate,
    output logic [7:0]        Rate,
    output logic [NREQ-1:0]   grant,
    output logic [NREQ-1:0]   ack,
    output logic              busy,
    output logic              timeout
);

    localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_WAIT_EDGE = 2'd1,
        ST_ACK       = 2'd2
    } state_t;

    state_t          state_r;
    state_t          state_nxt_s;
    logic            pwm_q_r;
    logic [IW-1:0]   ptr_r;
    logic [IW-1:0]   winner_r;
    logic [7:0]      pending_r;
    logic [7:0]      rate_r;
    logic [NREQ-1:0] grant_r;
    logic [NREQ-1:0] ack_r;
    logic            busy_r;
    logic            timeout_r;

    logic            found_s;
    logic [IW-1:0]   pick_s;
    logic [7:0]      pick_rate_s;
    logic            edge_s;
    logic            req_win_s;
    logic            fire_edge_s;
    logic            fire_tmo_s;
    logic            tmo_hit_s;
    logic [NREQ-1:0] grant_nxt_s;
    logic [NREQ-1:0] ack_nxt_s;
    logic            busy_nxt_s;
    logic            timeout_nxt_s;
    logic [7:0]      rate_nxt_s;

    function automatic logic [7:0] clamp_rate(input logic [7:0] r);
        clamp_rate = (r < MIN_RATE) ? MIN_RATE : r;
    endfunction

    function automatic logic [NREQ-1:0] onehot_idx(input logic [IW-1:0] i);
        logic [NREQ-1:0] v;
        v    = {NREQ{1'b0}};
        v[i] = 1'b1;
        onehot_idx = v;
    endfunction

    assign edge_s      = clk_pwm & ~pwm_q_r;
    assign req_win_s   = req[winner_r];
    assign pick_rate_s = clamp_rate(req_rate[{pick_s, 3'b000} +: 8]);

    // Round-robin search starting at ptr_r (the slot after the last served requester).
    always_comb begin
        found_s = 1'b0;
        pick_s  = {IW{1'b0}};
        for (int k = 0; k < NREQ; k++) begin
            pick_s  = (!found_s && req[(int'(ptr_r) + k) % NREQ])
                      ? IW'((int'(ptr_r) + k) % NREQ) : pick_s;
            found_s = found_s | req[(int'(ptr_r) + k) % NREQ];
        end
    end

`ifdef PWM_RATE_CTRL_TIMEOUT_EN
    logic [9:0] wait_cnt_r;

    assign tmo_hit_s = (wait_cnt_r == 10'(TIMEOUT - 1));

    // Wait counter: cleared on entry to WAIT_EDGE, counts while waiting.
    always_ff @(posedge clk) begin
        if (!reset) begin
            wait_cnt_r <= 10'd0;
        end else if (state_r != ST_WAIT_EDGE) begin
            wait_cnt_r <= 10'd0;
        end else begin
            wait_cnt_r <= wait_cnt_r + 10'd1;
        end
    end
`else
    assign tmo_hit_s = 1'b0;
`endif

    // A pending rate equal to the current one needs no edge: it completes like an edge.
    assign fire_edge_s = (state_r == ST_WAIT_EDGE) && (edge_s || (pending_r == rate_r));
    assign fire_tmo_s  = (state_r == ST_WAIT_EDGE) && !fire_edge_s && tmo_hit_s;

    // State register.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Next-state logic; edge beats a simultaneous withdrawal.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (found_s) begin
                    state_nxt_s = ST_WAIT_EDGE;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_WAIT_EDGE: begin
                if (fire_edge_s || fire_tmo_s) begin
                    state_nxt_s = ST_ACK;
                end else if (!req_win_s) begin
                    state_nxt_s = ST_IDLE;
                end else begin
                    state_nxt_s = ST_WAIT_EDGE;
                end
            end
            ST_ACK:  state_nxt_s = ST_IDLE;
            default: state_nxt_s = ST_IDLE;
        endcase
    end

    // Next values of the registered outputs.
    always_comb begin
        busy_nxt_s    = (state_nxt_s != ST_IDLE);
        ack_nxt_s     = (fire_edge_s || fire_tmo_s) ? onehot_idx(winner_r) : {NREQ{1'b0}};
        timeout_nxt_s = fire_tmo_s;
        rate_nxt_s    = (fire_edge_s || fire_tmo_s) ? pending_r : rate_r;
        if ((state_r == ST_IDLE) && found_s) begin
            grant_nxt_s = onehot_idx(pick_s);
        end else if (state_nxt_s == ST_IDLE) begin
            grant_nxt_s = {NREQ{1'b0}};
        end else begin
            grant_nxt_s = grant_r;
        end
    end

    // Edge-detect flop, arbitration bookkeeping and output registers.
    always_ff @(posedge clk) begin
        if (!reset) begin
            pwm_q_r   <= 1'b0;
            ptr_r     <= {IW{1'b0}};
            winner_r  <= {IW{1'b0}};
            pending_r <= INIT_RATE;
            rate_r    <= INIT_RATE;
            grant_r   <= {NREQ{1'b0}};
            ack_r     <= {NREQ{1'b0}};
            busy_r    <= 1'b0;
            timeout_r <= 1'b0;
        end else begin
            pwm_q_r   <= clk_pwm;
            rate_r    <= rate_nxt_s;
            grant_r   <= grant_nxt_s;
            ack_r     <= ack_nxt_s;
            busy_r    <= busy_nxt_s;
            timeout_r <= timeout_nxt_s;
            if ((state_r == ST_IDLE) && found_s) begin
                winner_r  <= pick_s;
                pending_r <= pick_rate_s;
            end else begin
                winner_r  <= winner_r;
                pending_r <= pending_r;
            end
            // The served requester drops to lowest priority.
            if (state_r == ST_ACK) begin
                ptr_r <= (winner_r == IW'(NREQ - 1)) ? {IW{1'b0}} : winner_r + IW'(1'b1);
            end else begin
                ptr_r <= ptr_r;
            end
        end
    end

    assign Rate    = rate_r;
    assign grant   = grant_r;
    assign ack     = ack_r;
    assign busy    = busy_r;
    assign timeout = timeout_r;

endmodule
